mem_port_arbiter: RTL

//   Shares the single core-to-memory port between instruction fetch (ibus) and
//   the memory stage (dbus). Latches one request, drives it downstream until

---
 rtl/mem_port_arbiter_pkg.sv | 61 ++++++
 rtl/mem_port_arbiter_arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core-to-memory port arbiter: bus request/response
// structs, access-size encodings and the arbiter FSM state enum.
package mem_port_arbiter_pkg;

    // Access size encodings (bytes = 1 << size)
    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    // Owner encoding for the round-robin history bit
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between fetch (ibus) and memory stage (dbus).
// Build option ARB_ROUND_ROBIN_EN: alternate on contention using the last
// owner; otherwise dbus wins unless a starving fetch has saturated its counter.
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic i_ivalid,
    input  logic i_dvalid,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_owner,
`else
    input  logic i_starve_sat,
`endif
    output logic o_grant_i,
    output logic o_grant_d
);

    // Pick at most one requester
    always_comb begin
        o_grant_i = 1'b0;
        o_grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_ivalid && i_dvalid) begin
            o_grant_i = (i_last_owner == OWNER_D);
            o_grant_d = (i_last_owner == OWNER_I);
        end else begin
            o_grant_i = i_ivalid;
            o_grant_d = i_dvalid;
        end
`else
        o_grant_d = i_dvalid && !(i_ivalid && i_starve_sat);
        o_grant_i = i_ivalid && (!i_dvalid || i_starve_sat);
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch (ibus) and memory stage
// (dbus). Latches one request, holds it until oresp.ready, routes the
// response to its owner. Build option ARB_ROUND_ROBIN_EN selects round-robin
// arbitration instead of dbus-first with starvation promotion.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  ibus_req_t  i_ireq,
    output ibus_resp_t o_iresp,
    input  dbus_req_t  i_dreq,
    output dbus_resp_t o_dresp,
    output cbus_req_t  o_oreq,
    input  cbus_resp_t i_oresp
);

    localparam int unsigned    CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_t      r_state, w_state_next;
    cbus_req_t       r_oreq, w_oreq_next;
    logic [CntW-1:0] r_starve_cnt, w_starve_cnt_next;
    logic            w_idle, w_done;
    logic            w_pick_i, w_pick_d, w_grant_i, w_grant_d;
    logic            w_unused_last;

    // Single-beat downstream: completion is signalled by ready alone
    assign w_unused_last = i_oresp.last;

    assign w_idle    = (r_state == IDLE);
    assign w_done    = !w_idle && i_oresp.ready;
    assign w_grant_i = w_idle && w_pick_i;
    assign w_grant_d = w_idle && w_pick_d;
    assign o_oreq    = r_oreq;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    // Remember who was granted last for alternation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_owner <= OWNER_I;
        end else if (w_grant_d) begin
            r_last_owner <= OWNER_D;
        end else if (w_grant_i) begin
            r_last_owner <= OWNER_I;
        end
    end

    mem_port_arbiter_arb_pick u_arb_pick (
        .i_ivalid     (i_ireq.valid),
        .i_dvalid     (i_dreq.valid),
        .i_last_owner (r_last_owner),
        .o_grant_i    (w_pick_i),
        .o_grant_d    (w_pick_d)
    );
`else
    logic w_starve_sat;
    assign w_starve_sat = (r_starve_cnt == CntMax);

    mem_port_arbiter_arb_pick u_arb_pick (
        .i_ivalid     (i_ireq.valid),
        .i_dvalid     (i_dreq.valid),
        .i_starve_sat (w_starve_sat),
        .o_grant_i    (w_pick_i),
        .o_grant_d    (w_pick_d)
    );
`endif

    // State, latched request and starvation counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_oreq       <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_oreq       <= w_oreq_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // Next state: grant from IDLE, return to IDLE on completion
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (i_oresp.ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch: capture on grant, hold while busy, clear on completion
    always_comb begin
        w_oreq_next = r_oreq;
        if (w_grant_d) begin
            w_oreq_next.valid    = 1'b1;
            w_oreq_next.is_write = |i_dreq.strobe;
            w_oreq_next.size     = i_dreq.size;
            w_oreq_next.addr     = i_dreq.addr;
            w_oreq_next.strobe   = i_dreq.strobe;
            w_oreq_next.data     = i_dreq.data;
        end else if (w_grant_i) begin
            w_oreq_next.valid    = 1'b1;
            w_oreq_next.is_write = 1'b0;
            w_oreq_next.size     = MSIZE4;
            w_oreq_next.addr     = i_ireq.addr;
            w_oreq_next.strobe   = '0;
            w_oreq_next.data     = '0;
        end else if (w_done) begin
            w_oreq_next = '0;
        end
    end

    // Count denied fetch cycles, saturating; clear on grant or no request
    always_comb begin
        w_starve_cnt_next = '0;
        if (i_ireq.valid && !w_grant_i) begin
            w_starve_cnt_next = (r_starve_cnt == CntMax) ? r_starve_cnt : r_starve_cnt + 1'b1;
        end
    end

    // Route the completing beat to its owner; the other side stays zero
    always_comb begin
        o_iresp = '0;
        o_dresp = '0;
        if (w_done && (r_state == BUSY_I)) begin
            o_iresp.addr_ok = 1'b1;
            o_iresp.data_ok = 1'b1;
            o_iresp.data    = r_oreq.addr[2] ? i_oresp.data[63:32] : i_oresp.data[31:0];
        end
        if (w_done && (r_state == BUSY_D)) begin
            o_dresp.addr_ok = 1'b1;
            o_dresp.data_ok = 1'b1;
            o_dresp.data    = i_oresp.data;
        end
    end

endmodule
